cache_write_ctrl: RTL and testbench

Upstream feeder for the tagged result cache. Accepts the partial-sum stream leaving a systolic-array column over a valid/ready handshake, tags each word with a sequential index, buffers it in a small FIFO, and issues single-cycle writes (`WE_0`, `data_i_0`, `index_i_0`) into the cache. Credit-based flow control tracks free cache slots so no write is issued when the cache is full; the downstream reader returns one credit per freed slot.

---
 rtl/cache_write_ctrl.sv | 136 +++++++++++++
 tb/tb_cache_write_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_ctrl.sv
// Tags the systolic-column partial-sum stream with sequential indices, buffers it and writes it into the result cache under credit flow control.
// Optional CACHE_WR_STALL_CNT_EN enables the credit-stall cycle counter on stall_cnt; otherwise stall_cnt is tied to zero.
module cache_write_ctrl #(
  parameter int Data_Width  = 16,
  parameter int Index_Width = 5,
  parameter int Fifo_Depth  = 4,
  parameter int Slots       = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Index_Width-1:0] cfg_base,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Data_Width-1:0]  in_data,
  input  logic                   in_last,
  output logic                   WE_0,
  output logic [Data_Width-1:0]  data_i_0,
  output logic [Index_Width-1:0] index_i_0,
  input  logic                   free_i,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            stall_cnt
);

  localparam int PtrW  = $clog2(Fifo_Depth);
  localparam int CredW = $clog2(Slots + 1);
  localparam int EntW  = Index_Width + Data_Width;
  localparam logic [PtrW:0]        PtrOne   = 1;
  localparam logic [CredW-1:0]     CredOne  = 1;
  localparam logic [CredW-1:0]     CredFull = CredW'(Slots);
  localparam logic [Index_Width-1:0] IdxOne = 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [Index_Width-1:0] idx_q, idx_d;
  logic [PtrW:0]          wr_ptr_q, rd_ptr_q;
  logic [EntW-1:0]        mem_q [Fifo_Depth];
  logic [CredW-1:0]       credits_q, credits_d;
  logic                   err_q, err_d;
  logic                   push, pop, empty, full, start_acc;
  logic [EntW-1:0]        head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

  assign pop       = !empty && (credits_q != '0);
  assign WE_0      = pop;
  assign data_i_0  = empty ? '0 : head[Data_Width-1:0];
  assign index_i_0 = empty ? '0 : head[EntW-1:Data_Width];
  assign err       = err_q;
  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_ready = 1'b0;
    push     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = RUN;
          idx_d   = cfg_base;
        end
      end
      RUN: begin
        in_ready = !full;
        push     = in_valid && !full;
        if (push) begin
          idx_d = idx_q + IdxOne;
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (empty) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (free_i && !pop) begin
      if (credits_q == CredFull) err_d = 1'b1;
      else                       credits_d = credits_q + CredOne;
    end else if (pop && !free_i) begin
      credits_d = credits_q - CredOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      credits_q <= CredFull;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {idx_q, in_data};
  end

`ifdef CACHE_WR_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || start_acc)
      stall_q <= '0;
    else if (!empty && (credits_q == '0) && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_write_ctrl.sv
// Bench for cache_write_ctrl: queue-based reference model compared every cycle, plus directed literal checks per scenario.
module tb_cache_write_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, free_i;
  logic [4:0]  cfg_base;
  logic [15:0] in_data;
  logic        in_ready, WE_0, done, err;
  logic [15:0] data_i_0, stall_cnt;
  logic [4:0]  index_i_0;

  int checks = 0;
  int failures = 0;

  cache_write_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .WE_0(WE_0), .data_i_0(data_i_0), .index_i_0(index_i_0),
    .free_i(free_i), .done(done), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a tile is either running, flushing, or neither (idle).
  logic [4:0]  m_idx_q[$];
  logic [15:0] m_dat_q[$];
  int          m_credits = 20;
  bit          m_running = 0, m_flushing = 0, m_err = 0;
  int          m_stall = 0;
  logic [4:0]  m_next_idx = 0;
  bit          armed = 0;
  int          cycle = 0;

  always @(posedge clk) begin
    bit we, acc, done_now, idle_pre, stalled;
    cycle++;
    if (rst) begin
      m_idx_q.delete(); m_dat_q.delete();
      m_credits = 20; m_running = 0; m_flushing = 0; m_err = 0;
      m_stall = 0; m_next_idx = 0;
    end else begin
      we       = (m_dat_q.size() > 0) && (m_credits > 0);
      acc      = m_running && (m_dat_q.size() < 4) && in_valid;
      done_now = m_flushing && (m_dat_q.size() == 0);
      idle_pre = !m_running && !m_flushing;
      stalled  = (m_dat_q.size() > 0) && (m_credits == 0);
      if (we) begin void'(m_idx_q.pop_front()); void'(m_dat_q.pop_front()); end
      if (free_i && !we) begin
        if (m_credits == 20) m_err = 1; else m_credits++;
      end else if (we && !free_i) m_credits--;
      if (stalled && m_stall < 16'hFFFF) m_stall++;
      if (acc) begin
        m_idx_q.push_back(m_next_idx); m_dat_q.push_back(in_data);
        m_next_idx = m_next_idx + 5'd1;
        if (in_last) begin m_running = 0; m_flushing = 1; end
      end
      if (done_now) m_flushing = 0;
      if (idle_pre && start) begin
        m_running = 1; m_next_idx = cfg_base; m_stall = 0;
      end
    end
  end

  // Observation log for literal checks.
  logic [4:0]  log_idx[$];
  logic [15:0] log_dat[$];
  int          done_cnt = 0, last_we_cycle = 0, done_cycle = 0;

  always @(negedge clk) begin
    bit          e_we, e_ready, e_done;
    logic [15:0] e_dat, e_stall;
    logic [4:0]  e_idx;
    if (armed) begin
      e_we    = (m_dat_q.size() > 0) && (m_credits > 0);
      e_ready = m_running && (m_dat_q.size() < 4);
      e_done  = m_flushing && (m_dat_q.size() == 0);
      e_dat   = (m_dat_q.size() > 0) ? m_dat_q[0] : 16'h0;
      e_idx   = (m_idx_q.size() > 0) ? m_idx_q[0] : 5'h0;
`ifdef CACHE_WR_STALL_CNT_EN
      e_stall = 16'(m_stall);
`else
      e_stall = 16'h0;
`endif
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("WE_0", 32'(WE_0), 32'(e_we));
      chk("data_i_0", 32'(data_i_0), 32'(e_dat));
      chk("index_i_0", 32'(index_i_0), 32'(e_idx));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
      if (WE_0 === 1'b1) begin
        log_idx.push_back(index_i_0); log_dat.push_back(data_i_0);
        last_we_cycle = cycle;
      end
      if (done === 1'b1) begin done_cnt++; done_cycle = cycle; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(1); rst = 1'b0;
  endtask

  task automatic clear_log();
    log_idx.delete(); log_dat.delete(); done_cnt = 0;
  endtask

  task automatic begin_tile(input logic [4:0] base);
    start = 1'b1; cfg_base = base; tick(1); start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    bit ok = 0;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!ok && n < 200) begin
      ok = in_ready;
      tick(1);
      n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_n(input int n, input logic [15:0] base_dat, input bit last_on_final);
    for (int i = 0; i < n; i++)
      send(base_dat + 16'(i), last_on_final && (i == n - 1));
  endtask

  task automatic pulse_free();
    free_i = 1'b1; tick(1); free_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; cfg_base = 0; in_valid = 0; in_last = 0; in_data = 0; free_i = 0;
    tick(1);
    armed = 1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_WE_0", 32'(WE_0), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);

    // Basic tile
    clear_log();
    begin_tile(5'd3);
    send_n(5, 16'h0010, 1);
    tick(6);
    chk("basic_writes", 32'(log_idx.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_idx.size(); i++) begin
      chk("basic_idx", 32'(log_idx[i]), 32'(3 + i));
      chk("basic_dat", 32'(log_dat[i]), 32'(16'h0010 + i));
    end
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_done_timing", 32'(done_cycle), 32'(last_we_cycle + 1));
    chk("basic_model_credits", 32'(m_credits), 32'd15);

    // Wrap
    do_reset(); clear_log();
    begin_tile(5'd30);
    send_n(4, 16'h0100, 1);
    tick(6);
    chk("wrap_writes", 32'(log_idx.size()), 32'd4);
    if (log_idx.size() == 4) begin
      chk("wrap_idx0", 32'(log_idx[0]), 32'd30);
      chk("wrap_idx1", 32'(log_idx[1]), 32'd31);
      chk("wrap_idx2", 32'(log_idx[2]), 32'd0);
      chk("wrap_idx3", 32'(log_idx[3]), 32'd1);
    end

    // Credit exhaustion
    do_reset(); clear_log();
    begin_tile(5'd0);
    send_n(24, 16'h0200, 1);
    tick(5);
    chk("exh_writes", 32'(log_idx.size()), 32'd20);
    chk("exh_in_ready", 32'(in_ready), 32'd0);
    chk("exh_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pulse_free(); tick(2);
    end
    chk("exh_writes_after_free", 32'(log_idx.size()), 32'd24);
    chk("exh_done_cnt", 32'(done_cnt), 32'd1);
    if (log_dat.size() == 24) chk("exh_last_dat", 32'(log_dat[23]), 32'h0217);

    // Free while stalled: one write, credits back to zero
    do_reset(); clear_log();
    begin_tile(5'd0);
    send_n(21, 16'h0300, 1);
    tick(4);
    chk("sim_writes_pre", 32'(log_idx.size()), 32'd20);
    pulse_free(); tick(3);
    chk("sim_writes_post", 32'(log_idx.size()), 32'd21);
    chk("sim_model_credits0", 32'(m_credits), 32'd0);

    // WE_0 and free_i together at credits=10
    do_reset(); clear_log();
    begin_tile(5'd0);
    send_n(10, 16'h0400, 0);
    tick(3);
    send(16'h040A, 0);
    free_i = 1'b1;
    chk("sim_we_with_free", 32'(WE_0), 32'd1);
    tick(1); free_i = 1'b0;
    chk("sim_model_credits10", 32'(m_credits), 32'd10);
    send_n(11, 16'h0500, 1);
    tick(5);
    chk("sim_total_writes", 32'(log_idx.size()), 32'd21);
    chk("sim_no_err", 32'(err), 32'd0);

    // Overflow
    do_reset(); clear_log();
    pulse_free();
    chk("ovf_err_set", 32'(err), 32'd1);
    tick(3);
    chk("ovf_err_sticky", 32'(err), 32'd1);
    begin_tile(5'd0);
    send_n(21, 16'h0600, 1);
    tick(4);
    chk("ovf_credits_stay20", 32'(log_idx.size()), 32'd20);
    do_reset();
    chk("ovf_err_cleared", 32'(err), 32'd0);

    // Reset mid-tile with two words buffered
    clear_log();
    begin_tile(5'd0);
    send_n(20, 16'h0700, 1);
    tick(3);
    begin_tile(5'd8);
    send_n(2, 16'h0800, 0);
    tick(2);
    clear_log();
    do_reset();
    tick(4);
    chk("mid_no_we", 32'(log_idx.size()), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    begin_tile(5'd9);
    send(16'h0900, 1);
    tick(3);
    chk("mid_credits_back", 32'(log_idx.size()), 32'd1);
    if (log_idx.size() == 1) chk("mid_new_idx", 32'(log_idx[0]), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
